// File: rtl/feed_pkg.sv
// Shared constants for the feed cycle controller: FSM state codes and cam angles.
package feed_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARMED   = 3'd1;
  localparam state_t ST_RUNNING = 3'd2;
  localparam state_t ST_COAST   = 3'd3;
  localparam state_t ST_ERROR   = 3'd4;

  localparam int REST_ANGLE     = 315;
  localparam int PRE_REST_ANGLE = REST_ANGLE - 1;
  localparam int LP_ANGLE_A     = 75;
  localparam int LP_ANGLE_B     = 195;
  localparam int LP_ANGLE_C     = 315;
  localparam int CONT_WRAP      = 359;

endpackage

// File: rtl/cam_event_det.sv
// Decodes shaft angles into the latch-point and about-to-rest (completion) events.
module cam_event_det
  import feed_pkg::*;
(
  input  int   cont_angle,
  input  int   clch_angle,
  input  logic sync_mode,
  output logic lp,
  output logic pre_rest
);

  logic clch_at_rest;
  logic cont_at_lp;

  assign clch_at_rest = (clch_angle == REST_ANGLE);
  // Synchronous mode only engages in phase with the continuous shaft's rest angle.
  assign cont_at_lp   = (cont_angle == LP_ANGLE_C) ||
                        (!sync_mode && ((cont_angle == LP_ANGLE_A) || (cont_angle == LP_ANGLE_B)));
  assign lp           = clch_at_rest && cont_at_lp;
  assign pre_rest     = (clch_angle == PRE_REST_ANGLE);

endmodule

// File: rtl/feed_cycle_ctrl.sv
// Feed cycle controller: commands the clutch latch, counts completed clutched
// revolutions and flags clutches that fail to engage in time.
module feed_cycle_ctrl
  import feed_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MAX_WAIT_REV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             power,
  input  int               cont_angle,
  input  int               clch_angle,
  input  logic             sync_mode,
  input  logic             feed_req,
  input  logic             stop_req,
  output logic             clch_latch,
  output logic             busy,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             feed_err
);

  localparam int REV_W = (MAX_WAIT_REV > 1) ? $clog2(MAX_WAIT_REV) : 1;

  state_t             state_q, state_d;
  logic               latch_q, latch_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REV_W-1:0]   rev_q, rev_d;

  logic lp, pre_rest, complete, clch_at_rest;

  cam_event_det u_det (
    .cont_angle (cont_angle),
    .clch_angle (clch_angle),
    .sync_mode  (sync_mode),
    .lp         (lp),
    .pre_rest   (pre_rest)
  );

  assign clch_at_rest = (clch_angle == REST_ANGLE);
  assign complete     = pre_rest && power && ((state_q == ST_RUNNING) || (state_q == ST_COAST));

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    rev_d   = rev_q;
    err_d   = err_q;
    done_d  = complete;
    cnt_d   = complete ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      ST_IDLE: begin
        latch_d = 1'b0;
        if (feed_req && !stop_req) begin
          state_d = ST_ARMED;
          latch_d = 1'b1;
          rev_d   = '0;
        end
      end
      ST_ARMED: begin
        if (stop_req && clch_at_rest) begin
          state_d = ST_IDLE;
          latch_d = 1'b0;
        end else if (!clch_at_rest) begin
          state_d = ST_RUNNING;
        end else if (power && (cont_angle == CONT_WRAP)) begin
          if (rev_q == REV_W'(MAX_WAIT_REV - 1)) begin
            state_d = ST_ERROR;
            latch_d = 1'b0;
            err_d   = 1'b1;
          end else begin
            rev_d = rev_q + REV_W'(1);
          end
        end
      end
      ST_RUNNING: begin
        // Dropping the latch on the completing edge leaves the clutch at rest, so skip COAST.
        if (!feed_req || stop_req) begin
          latch_d = 1'b0;
          state_d = complete ? ST_IDLE : ST_COAST;
        end
      end
      ST_COAST: begin
        latch_d = 1'b0;
        if (complete) state_d = ST_IDLE;
      end
      ST_ERROR: begin
        latch_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        latch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      latch_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rev_q   <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rev_q   <= rev_d;
    end
  end

  assign clch_latch  = latch_q;
  assign busy        = (state_q != ST_IDLE);
  assign cycle_done  = done_q;
  assign cycle_count = cnt_q;
  assign feed_err    = err_q;

endmodule

// File: tb/tb_feed_cycle_ctrl.sv
// Bench for feed_cycle_ctrl: a cam-assembly plant drives the shaft angles and a
// revolution-ownership model predicts completions and the cycle count.
module tb_feed_cycle_ctrl;

  localparam int CNT_W        = 3;
  localparam int MAX_WAIT_REV = 2;

  logic clk = 1'b0;
  logic rst = 1'b1, power = 1'b1, sync_mode = 1'b1, feed_req = 1'b0, stop_req = 1'b0;
  int   cont_angle = 0, clch_angle = 315;
  logic clch_latch, busy, cycle_done, feed_err;
  logic [CNT_W-1:0] cycle_count;

  int vectors = 0, miscompares = 0;

  bit stuck = 0, owned = 0, ev_engage = 0, ev_complete = 0, exp_done = 0;
  int ev_cont = 0, exp_cnt = 0;

  feed_cycle_ctrl #(.CNT_W(CNT_W), .MAX_WAIT_REV(MAX_WAIT_REV)) dut (
    .clk (clk), .rst (rst), .power (power), .cont_angle (cont_angle),
    .clch_angle (clch_angle), .sync_mode (sync_mode), .feed_req (feed_req),
    .stop_req (stop_req), .clch_latch (clch_latch), .busy (busy),
    .cycle_done (cycle_done), .cycle_count (cycle_count), .feed_err (feed_err)
  );

  always #5 clk = ~clk;

  function automatic bit plant_lp(int c, logic s);
    return (c == 315) || (!s && (c == 75 || c == 195));
  endfunction

  // One clock of the mechanical assembly; a revolution is owned by the controller
  // if it engaged since the last reset, and each owned revolution counts once.
  task automatic tick();
    int nc, nk;
    bit eng, cmp;
    nc = cont_angle; nk = clch_angle; eng = 0; cmp = 0;
    if (power) begin
      nc = (cont_angle + 1) % 360;
      if (stuck) nk = 315;
      else if (clch_angle == 315) begin
        if (clch_latch === 1'b1 && plant_lp(cont_angle, sync_mode)) begin nk = 316; eng = 1; end
      end else begin
        nk = (clch_angle + 1) % 360;
        cmp = (clch_angle == 314);
      end
    end
    ev_cont = cont_angle; ev_engage = eng; ev_complete = cmp;
    if (rst) begin
      owned = 0; exp_cnt = 0; exp_done = 0;
    end else begin
      exp_done = cmp && owned;
      if (exp_done) begin exp_cnt = (exp_cnt + 1) % (1 << CNT_W); owned = 0; end
      if (eng) owned = 1;
    end
    @(posedge clk); #1;
    cont_angle = nc; clch_angle = nk;
  endtask

  task automatic do_reset();
    rst = 1; feed_req = 0; stop_req = 0; power = 1; stuck = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic place(int c, int k, logic s);
    cont_angle = c; clch_angle = k; sync_mode = s;
  endtask

  task automatic test_reset();
    rst = 1; feed_req = 1; power = 1;
    repeat (3) tick();
    vectors += 5;
    if (clch_latch !== 1'b0) begin miscompares++; $display("FAIL reset_latch: got %b expected 0", clch_latch); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (cycle_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", cycle_done); end
    if (cycle_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", cycle_count); end
    if (feed_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", feed_err); end
    feed_req = 0; rst = 0;
  endtask

  task automatic test_sync_single();
    int eng_cont = -1;
    bit done = 0;
    do_reset(); place(100, 315, 1'b1);
    feed_req = 1; tick(); feed_req = 0;
    vectors++;
    if (clch_latch !== 1'b1) begin miscompares++; $display("FAIL sync_latch_rise: got %b expected 1", clch_latch); end
    for (int n = 0; n < 800 && !done; n++) begin
      tick();
      if (ev_engage) eng_cont = ev_cont;
      if (ev_complete) done = 1;
    end
    vectors += 4;
    if (!done) begin miscompares++; $display("FAIL sync_timeout: got no completion expected one"); end
    if (eng_cont != 315) begin miscompares++; $display("FAIL sync_eng_angle: got %0d expected 315", eng_cont); end
    if (cycle_done !== 1'b1 || cycle_count !== CNT_W'(1)) begin
      miscompares++; $display("FAIL sync_done_count: got done=%b count=%0d expected 1/1", cycle_done, cycle_count);
    end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL sync_idle: got busy=%b expected 0", busy); end
    tick();
    if (cycle_done !== 1'b0 || clch_latch !== 1'b0) begin
      miscompares++; $display("FAIL sync_pulse_end: got done=%b latch=%b expected 0/0", cycle_done, clch_latch);
    end
  endtask

  task automatic test_async_lp();
    int eng_cont = -1;
    bit done = 0;
    do_reset(); place(60, 315, 1'b0);
    feed_req = 1; tick(); feed_req = 0;
    for (int n = 0; n < 400 && eng_cont < 0; n++) begin
      tick();
      if (ev_engage) eng_cont = ev_cont;
    end
    for (int n = 0; n < 400 && !done; n++) begin
      tick();
      if (ev_complete) done = 1;
    end
    vectors += 2;
    if (eng_cont != 75) begin miscompares++; $display("FAIL async_eng_angle: got %0d expected 75", eng_cont); end
    if (!done || cycle_count !== CNT_W'(1) || cycle_done !== 1'b1) begin
      miscompares++; $display("FAIL async_count: got count=%0d done=%b expected 1/1", cycle_count, cycle_done);
    end
  endtask

  task automatic test_continuous();
    int ncomp = 0, neng = 0;
    do_reset(); place(100, 315, 1'b1);
    feed_req = 1;
    for (int n = 0; n < 2000 && ncomp < 3; n++) begin
      tick();
      if (ev_complete) begin
        ncomp++;
        vectors++;
        if (cycle_done !== 1'b1) begin miscompares++; $display("FAIL cont_done_%0d: got %b expected 1", ncomp, cycle_done); end
        if (ncomp < 3) begin
          vectors++;
          if (clch_latch !== 1'b1) begin miscompares++; $display("FAIL cont_latch_held_%0d: got %b expected 1", ncomp, clch_latch); end
        end
      end
      if (ncomp == 2 && feed_req && clch_angle == 100) begin
        feed_req = 0; tick();
        vectors++;
        if (clch_latch !== 1'b0 || busy !== 1'b1) begin
          miscompares++; $display("FAIL cont_latch_drop: got latch=%b busy=%b expected 0/1", clch_latch, busy);
        end
      end
    end
    vectors += 2;
    if (ncomp != 3) begin miscompares++; $display("FAIL cont_timeout: got %0d completions expected 3", ncomp); end
    if (cycle_count !== CNT_W'(3) || busy !== 1'b0) begin
      miscompares++; $display("FAIL cont_count: got count=%0d busy=%b expected 3/0", cycle_count, busy);
    end
    repeat (400) begin tick(); if (ev_engage) neng++; end
    vectors++;
    if (neng != 0 || cycle_count !== CNT_W'(3)) begin
      miscompares++; $display("FAIL cont_quiet: got engagements=%0d count=%0d expected 0/3", neng, cycle_count);
    end
  endtask

  task automatic test_stuck();
    int xings = 0;
    bit x;
    do_reset(); place(100, 315, 1'b1); stuck = 1;
    feed_req = 1; tick(); feed_req = 0;
    for (int n = 0; n < 1000 && xings < 2; n++) begin
      x = power && (cont_angle == 359);
      tick();
      if (x) begin
        xings++;
        vectors++;
        if (xings == 1 && (feed_err !== 1'b0 || clch_latch !== 1'b1)) begin
          miscompares++; $display("FAIL stuck_first: got err=%b latch=%b expected 0/1", feed_err, clch_latch);
        end
        if (xings == 2 && (feed_err !== 1'b1 || clch_latch !== 1'b0 || busy !== 1'b1)) begin
          miscompares++; $display("FAIL stuck_err: got err=%b latch=%b busy=%b expected 1/0/1", feed_err, clch_latch, busy);
        end
      end
    end
    vectors++;
    if (xings != 2) begin miscompares++; $display("FAIL stuck_timeout: got %0d crossings expected 2", xings); end
    feed_req = 1;
    repeat (20) tick();
    vectors++;
    if (feed_err !== 1'b1 || busy !== 1'b1 || clch_latch !== 1'b0) begin
      miscompares++; $display("FAIL stuck_sticky: got err=%b busy=%b latch=%b expected 1/1/0", feed_err, busy, clch_latch);
    end
    feed_req = 0; stuck = 0;
  endtask

  task automatic test_power_pause();
    int ndone = 0;
    bit found = 0;
    do_reset(); place(100, 315, 1'b1);
    feed_req = 1;
    for (int n = 0; n < 1000 && !found; n++) begin
      tick();
      if (clch_angle == 314) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL pause_timeout: got no clch 314 expected one"); end
    power = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      vectors++;
      if (cycle_done !== 1'b0 || busy !== 1'b1 || clch_latch !== 1'b1) begin
        miscompares++; $display("FAIL pause_hold_%0d: got done=%b busy=%b latch=%b expected 0/1/1", n, cycle_done, busy, clch_latch);
      end
    end
    power = 1; feed_req = 0;
    repeat (500) begin tick(); if (cycle_done) ndone++; end
    vectors++;
    if (ndone != 1 || cycle_count !== CNT_W'(1) || busy !== 1'b0 || clch_latch !== 1'b0) begin
      miscompares++; $display("FAIL pause_resume: got pulses=%0d count=%0d busy=%b latch=%b expected 1/1/0/0", ndone, cycle_count, busy, clch_latch);
    end
  endtask

  task automatic test_rst_midcycle();
    int ndone = 0;
    bit found = 0;
    do_reset(); place(100, 315, 1'b1);
    feed_req = 1;
    for (int n = 0; n < 1500 && !found; n++) begin
      tick();
      if (exp_cnt == 1 && clch_angle == 200) found = 1;
    end
    rst = 1; feed_req = 0; tick(); rst = 0;
    vectors++;
    if (!found || clch_latch !== 1'b0 || busy !== 1'b0 || cycle_done !== 1'b0 || cycle_count !== '0 || feed_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got found=%b latch=%b busy=%b done=%b count=%0d err=%b expected 1/0/0/0/0/0",
               found, clch_latch, busy, cycle_done, cycle_count, feed_err);
    end
    repeat (500) begin tick(); if (cycle_done) ndone++; end
    vectors++;
    if (ndone != 0 || cycle_count !== '0 || clch_latch !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_nocount: got pulses=%0d count=%0d latch=%b expected 0/0/0", ndone, cycle_count, clch_latch);
    end
  endtask

  task automatic test_wrap();
    int ncomp = 0;
    do_reset(); place(300, 315, 1'b1);
    feed_req = 1;
    for (int n = 0; n < 4000 && ncomp < 9; n++) begin
      tick();
      if (ev_complete) ncomp++;
    end
    vectors++;
    if (ncomp != 9 || cycle_count !== CNT_W'(1) || cycle_done !== 1'b1 || feed_err !== 1'b0) begin
      miscompares++; $display("FAIL wrap: got comps=%0d count=%0d done=%b err=%b expected 9/1/1/0", ncomp, cycle_count, cycle_done, feed_err);
    end
    feed_req = 0;
  endtask

  task automatic test_random();
    do_reset(); place($urandom_range(359), 315, 1'b1);
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(99) == 0) sync_mode = ~sync_mode;
      power = ($urandom_range(9) != 0);
      if ($urandom_range(299) == 0) feed_req = ~feed_req;
      // Keep stop away from latch-point angles, where stop and engagement would race.
      stop_req = ($urandom_range(29) == 0) && !(cont_angle == 75 || cont_angle == 195 || cont_angle == 315);
      tick();
      vectors++;
      if (cycle_done !== exp_done || cycle_count !== CNT_W'(exp_cnt) || feed_err !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_%0d: got done=%b count=%0d err=%b expected %b/%0d/0", n, cycle_done, cycle_count, feed_err, exp_done, exp_cnt);
      end
    end
    feed_req = 0; stop_req = 0; power = 1;
    repeat (800) tick();
    vectors++;
    if (busy !== 1'b0 || clch_latch !== 1'b0) begin
      miscompares++; $display("FAIL rand_settle: got busy=%b latch=%b expected 0/0", busy, clch_latch);
    end
  endtask

  initial begin
    test_reset();
    test_sync_single();
    test_async_lp();
    test_continuous();
    test_stuck();
    test_power_pause();
    test_rst_midcycle();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/feed_cycle_ctrl.md
FEED_CYCLE_CTRL -- requirements
Module: feed_cycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning width of the completed-cycle counter.
REQ-002 SHALL have parameter MAX_WAIT_REV, default 2, meaning the number of continuous-shaft revolutions allowed for clutch engagement before an error is raised.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port power  input  1  shafts advance one degree per clk when high.
REQ-006 SHALL have port cont_angle  input  int  continuous shaft angle, 0..359.
REQ-007 SHALL have port clch_angle  input  int  clutched shaft angle, 0..359, rest 315.
REQ-008 SHALL have port sync_mode  input  1  1 = engage only at 315; 0 = engage at 75, 195 or 315.
REQ-009 SHALL have port feed_req  input  1  level request for feed cycles; held high = run continuously.
REQ-010 SHALL have port stop_req  input  1  stop after the current cycle.
REQ-011 SHALL have port clch_latch  output  1  clutch latch command to the cam assembly.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port cycle_done  output  1  one-clk pulse at each completed clutched revolution.
REQ-014 SHALL have port cycle_count  output  CNT_W  completed cycles; wraps at 2^CNT_W.
REQ-015 SHALL have port feed_err  output  1  sticky engagement-timeout error.

Function
REQ-016 SHALL implement states IDLE, ARMED, RUNNING, COAST, ERROR.
REQ-017 Latch point (LP) SHALL be defined as clch_angle==315 and (cont_angle==315, or, if sync_mode==0, cont_angle==75 or 195).
REQ-018 IDLE->ARMED SHALL occur when feed_req==1 and stop_req==0; clch_latch SHALL rise on that same transition edge.
REQ-019 In ARMED, clch_latch SHALL be held at 1; ARMED->RUNNING SHALL occur on the first clk where clch_angle!=315 (engagement observed).
REQ-020 In ARMED, a revolution counter SHALL increment each clk with power==1 and cont_angle==359; when it reaches MAX_WAIT_REV, the block SHALL go to ERROR, drop clch_latch and set feed_err.
REQ-021 A cycle completion SHALL be detected when clch_angle==314, power==1 and the state is RUNNING or COAST; cycle_done SHALL pulse on the next clk, and cycle_count SHALL increment on that same clk.
REQ-022 In RUNNING, clch_latch SHALL be 1 while feed_req==1 and stop_req==0; otherwise clch_latch SHALL drop and the state SHALL go to COAST.
REQ-023 COAST SHALL hold clch_latch==0; at cycle completion it SHALL go to IDLE.
REQ-024 If feed_req re-asserts in COAST, the block SHALL NOT re-latch until IDLE is reached.
REQ-025 With power==0, angles are frozen: no completion SHALL be detected, the revolution counter SHALL hold, and the state SHALL hold except for REQ-022 and REQ-026.
REQ-026 stop_req in ARMED SHALL return the block to IDLE with clch_latch==0 if clch_angle is still 315.
REQ-027 Simultaneous stop_req and feed_req SHALL resolve as stop (stop_req has priority).
REQ-028 ERROR SHALL be left only by rst; busy SHALL be 1 in ERROR.
REQ-029 cycle_count SHALL wrap from 2^CNT_W-1 to 0 without error.

Reset
REQ-030 On rst: state=IDLE, clch_latch=0, busy=0, cycle_done=0, cycle_count=0, feed_err=0, revolution counter=0.
REQ-031 rst mid-cycle SHALL drop clch_latch immediately; the assembly finishes its revolution mechanically, and the controller SHALL NOT count that completion.

Structure
REQ-032 The state enum, rest angle 315 and latch-point angles 75/195/315 SHALL live in a shared package feed_pkg.
REQ-033 Latch-point and completion detection SHALL be one sub-module, cam_event_det (combinational, angle in -> lp, pre_rest out).

Verification
REQ-034 Bench SHALL cover: sync_mode=1, feed_req pulse at cont_angle=100 -> engagement at cont 315; cycle_done one clk after clch 314; count=1; IDLE.
REQ-035 Bench SHALL cover: sync_mode=0, request at cont_angle=60 -> clch_angle leaves 315 after cont 75, not after 315.
REQ-036 Bench SHALL cover: feed_req held for 3 cycles then dropped -> clch_latch stays high through 2 completions, drops after the 3rd request cycle; count=3.
REQ-037 Bench SHALL cover: clutch stuck (clch_angle forced 315), MAX_WAIT_REV=2 -> feed_err=1 after 2 cont 359 crossings; clch_latch=0.
REQ-038 Bench SHALL cover: power=0 for 50 clks mid-RUNNING -> no cycle_done and state held; resuming gives exactly one completion.
REQ-039 Bench SHALL cover: rst at clch_angle=200 -> all outputs 0 next clk; the subsequent pass through 314 gives no cycle_done.
